// File: rtl/prod_accumulator.sv
// prod_accumulator
//   Accumulates unsigned products from the 4x4 multiplier into a wide sum.
//   A group ends after LEN products or when in_last is seen on an accepted
//   product. The finished sum is held on a valid/ready output port until the
//   consumer takes it.
//
// Parameters
//   PW  : product width (matches the multiplier output)
//   AW  : accumulator / out_sum width, AW >= PW
//   LEN : products per group, 1..255
//
// Ports
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     : product handshake, in_prod data, in_last early close
//   out_valid/out_ready   : result handshake
//   out_sum               : group sum modulo 2^AW
//   out_cnt               : number of products in the group
//   out_ovf               : sticky carry out of bit AW-1 during the group
module prod_accumulator #(
  parameter int PW  = 8,
  parameter int AW  = 16,
  parameter int LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [7:0]    out_cnt,
  output logic          out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_acc;
  logic [7:0]    r_cnt;
  logic          r_ovf;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_accept;
  logic          w_release;
  logic [AW:0]   w_sum;
  logic [7:0]    w_cnt_inc;
  logic          w_close;

  // One extra bit on the adder captures the carry that feeds the sticky flag.
  assign w_sum     = {1'b0, r_acc} + {{(AW + 1 - PW){1'b0}}, in_prod};
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_close   = in_last || (w_cnt_inc == 8'(LEN));
  assign w_accept  = w_in_ready && in_valid;
  assign w_release = w_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE, S_ACC: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_next = w_close ? S_HOLD : S_ACC;
        end
      end
      S_HOLD: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum[AW-1:0];
      r_cnt <= w_cnt_inc;
      r_ovf <= r_ovf | w_sum[AW];
    end else if (w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end
  end

  // Result fields read as zero whenever no result is being offered.
  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_sum   = w_out_valid ? r_acc : '0;
  assign out_cnt   = w_out_valid ? r_cnt : '0;
  assign out_ovf   = w_out_valid & r_ovf;

endmodule
